// File: rtl/high_priority_encoder_n_sync_pkg.sv
// ---------------------------------------------------------------------------
// high_priority_encoder_pkg
//   Shared types and helpers for the registered N:log2(N) priority encoder.
//   - encoder_mode_t : run-time search mode (fixed priority / round-robin)
//   - rot_src_index  : masked index arithmetic used to rotate the request
//                      vector so that the search start sits at the top bit.
//   Optional feature macro used by the top: HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
// ---------------------------------------------------------------------------
package high_priority_encoder_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } encoder_mode_t;

  // Source bit for rotated position 'offset' when the descending search starts
  // at 'start': rot[offset] = vec[(start + 1 + offset) mod n]. With this
  // mapping rot[n-1] = vec[start], rot[n-2] = vec[start-1], ... so a plain
  // highest-set-bit search over rot walks downwards from start and wraps.
  // n is a power of two, so the modulo is a mask.
  function automatic logic [31:0] rot_src_index(input logic [31:0] start,
                                                input logic [31:0] offset,
                                                input logic [31:0] n);
    return (start + offset + 32'd1) & (n - 32'd1);
  endfunction

endpackage

// File: rtl/high_priority_encoder_n_sync_priority_search_core.sv
// ---------------------------------------------------------------------------
// priority_search_core
//   Purely combinational descending search with wrap-around.
//   Ports:
//     vec_i    [NUM_INPUTS]  request vector
//     start_i  [OUT_WIDTH]   first index examined (search descends, wraps
//                            from 0 to NUM_INPUTS-1)
//     winner_o [OUT_WIDTH]   first set index found (0 when none)
//     found_o                at least one request bit set
//   start_i = NUM_INPUTS-1 gives plain highest-index-wins priority.
// ---------------------------------------------------------------------------
module priority_search_core
  import high_priority_encoder_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int OUT_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] vec_i,
  input  logic [OUT_WIDTH-1:0]  start_i,
  output logic [OUT_WIDTH-1:0]  winner_o,
  output logic                  found_o
);

  logic [NUM_INPUTS-1:0] rot;
  logic [OUT_WIDTH-1:0]  sel_pos;

  // Rotate so the search start lands on the MSB of rot.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_rot
    logic [OUT_WIDTH-1:0] src_idx;
    assign src_idx = OUT_WIDTH'(rot_src_index(32'(start_i), 32'(gi), 32'(NUM_INPUTS)));
    assign rot[gi] = vec_i[src_idx];
  end

  // Highest set position in the rotated vector; later iterations override.
  always_comb begin
    sel_pos = '0;
    found_o = 1'b0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      if (rot[j]) begin
        sel_pos = OUT_WIDTH'(j);
        found_o = 1'b1;
      end
    end
  end

  // Undo the rotation; wraps naturally in OUT_WIDTH bits. Forced to 0 when
  // nothing was found so the encoded value is deterministic.
  assign winner_o = found_o ? (start_i + sel_pos + OUT_WIDTH'(1)) : '0;

endmodule

// File: rtl/high_priority_encoder_n_sync.sv
// ---------------------------------------------------------------------------
// high_priority_encoder_n_sync
//   Registered N:log2(N) priority encoder with valid/ready on both sides and
//   two run-time modes: fixed (highest index wins) and round-robin (search
//   starts one below the last winner).
//   Ports:
//     Clock_In, Reset_In        clock, synchronous active-high reset
//     Enable_In                 0 blocks new input transactions
//     Mode_In                   0 fixed, 1 round-robin (sampled on accept)
//     Data_In [NUM_INPUTS]      request vector
//     Valid_In / Ready_Out      input handshake
//     Encoded_Value_Out         winning index
//     No_Request_Out            accepted vector was all-zero
//     Valid_Out / Ready_In      output handshake
//     Grant_OneHot_Out          one-hot winner (only with the macro below)
//   Optional feature macro: HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
//   NUM_INPUTS must be a power of two and >= 2.
// ---------------------------------------------------------------------------
module high_priority_encoder_n_sync
  import high_priority_encoder_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  localparam int OUT_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Mode_In,
  input  logic [NUM_INPUTS-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready_Out,
  output logic [OUT_WIDTH-1:0]  Encoded_Value_Out,
  output logic                  No_Request_Out,
  output logic                  Valid_Out,
  input  logic                  Ready_In
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
  ,
  output logic [NUM_INPUTS-1:0] Grant_OneHot_Out
`endif
);

  logic                 valid_q,      valid_d;
  logic [OUT_WIDTH-1:0] enc_q,        enc_d;
  logic                 no_req_q,     no_req_d;
  logic [OUT_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                 accept;
  logic                 consume;
  encoder_mode_t        mode;
  logic [OUT_WIDTH-1:0] search_start;
  logic [OUT_WIDTH-1:0] winner;
  logic                 found;

  assign mode      = encoder_mode_t'(Mode_In);
  assign Ready_Out = Enable_In && (!valid_q || Ready_In);
  assign accept    = Valid_In && Ready_Out;
  assign consume   = valid_q && Ready_In;

  // Round-robin starts one below the last winner (wrapping); after reset the
  // pointer is 0, so the start is NUM_INPUTS-1, same as fixed mode.
  assign search_start = (mode == MODE_RR) ? (last_grant_q - OUT_WIDTH'(1))
                                          : OUT_WIDTH'(NUM_INPUTS - 1);

  priority_search_core #(
    .NUM_INPUTS (NUM_INPUTS),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_search (
    .vec_i    (Data_In),
    .start_i  (search_start),
    .winner_o (winner),
    .found_o  (found)
  );

  always_comb begin
    valid_d      = valid_q;
    enc_d        = enc_q;
    no_req_d     = no_req_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      valid_d  = 1'b1;
      enc_d    = winner;
      no_req_d = !found;
      // An empty vector leaves the round-robin pointer where it was.
      if (found) begin
        last_grant_d = winner;
      end
    end else if (consume) begin
      // Data outputs hold their last value after being consumed.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      valid_q      <= 1'b0;
      enc_q        <= '0;
      no_req_q     <= 1'b0;
      last_grant_q <= '0;
    end else begin
      valid_q      <= valid_d;
      enc_q        <= enc_d;
      no_req_q     <= no_req_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign Valid_Out         = valid_q;
  assign Encoded_Value_Out = enc_q;
  assign No_Request_Out    = no_req_q;

`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
  logic [NUM_INPUTS-1:0] onehot_q, onehot_d;

  always_comb begin
    onehot_d = onehot_q;
    if (accept) begin
      onehot_d = found ? (NUM_INPUTS'(1) << winner) : '0;
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      onehot_q <= '0;
    end else begin
      onehot_q <= onehot_d;
    end
  end

  assign Grant_OneHot_Out = onehot_q;
`endif

endmodule

// File: tb/tb_high_priority_encoder_n_sync.sv
module tb_high_priority_encoder_n_sync;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         Reset_In;
  logic         Enable_In;
  logic         Mode_In;
  logic [N-1:0] Data_In;
  logic         Valid_In;
  logic         Ready_Out;
  logic [W-1:0] Encoded_Value_Out;
  logic         No_Request_Out;
  logic         Valid_Out;
  logic         Ready_In;
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
  logic [N-1:0] Grant_OneHot_Out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  high_priority_encoder_n_sync #(.NUM_INPUTS(N)) dut (
    .Clock_In          (clk),
    .Reset_In          (Reset_In),
    .Enable_In         (Enable_In),
    .Mode_In           (Mode_In),
    .Data_In           (Data_In),
    .Valid_In          (Valid_In),
    .Ready_Out         (Ready_Out),
    .Encoded_Value_Out (Encoded_Value_Out),
    .No_Request_Out    (No_Request_Out),
    .Valid_Out         (Valid_Out),
    .Ready_In          (Ready_In)
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
    ,
    .Grant_OneHot_Out  (Grant_OneHot_Out)
`endif
  );

  // Advance one rising edge, then settle 1ns past it before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_In  = 1'b1;
    Valid_In  = 1'b0;
    Ready_In  = 1'b1;
    Enable_In = 1'b1;
    Mode_In   = 1'b0;
    Data_In   = '0;
    tick();
    Reset_In  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (Valid_Out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", Valid_Out); end
    checks++;
    if (Encoded_Value_Out !== 3'd0) begin errors++; $display("FAIL reset_enc got %0d exp 0", Encoded_Value_Out); end
    checks++;
    if (No_Request_Out !== 1'b0) begin errors++; $display("FAIL reset_noreq got %b exp 0", No_Request_Out); end
    checks++;
    if (Ready_Out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", Ready_Out); end
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
    checks++;
    if (Grant_OneHot_Out !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h exp 00", Grant_OneHot_Out); end
`endif
    $display("test_reset: outputs after reset valid=%b enc=%0d", Valid_Out, Encoded_Value_Out);
  endtask

  task automatic test_fixed();
    logic [N-1:0] vecs [3];
    logic [W-1:0] exp_enc [3];
    logic [N-1:0] exp_oh [3];
    vecs[0] = 8'b0010_1100; exp_enc[0] = 3'd5; exp_oh[0] = 8'h20;
    vecs[1] = 8'h01;        exp_enc[1] = 3'd0; exp_oh[1] = 8'h01;
    vecs[2] = 8'h81;        exp_enc[2] = 3'd7; exp_oh[2] = 8'h80;
    do_reset();
    Mode_In = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Data_In  = vecs[i];
      Valid_In = 1'b1;
      tick();
      checks++;
      if (Valid_Out !== 1'b1 || Encoded_Value_Out !== exp_enc[i] || No_Request_Out !== 1'b0) begin
        errors++;
        $display("FAIL fixed_%0d got v=%b enc=%0d nr=%b exp v=1 enc=%0d nr=0",
                 i, Valid_Out, Encoded_Value_Out, No_Request_Out, exp_enc[i]);
      end
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
      checks++;
      if (Grant_OneHot_Out !== exp_oh[i]) begin errors++; $display("FAIL fixed_onehot_%0d got %h exp %h", i, Grant_OneHot_Out, exp_oh[i]); end
`endif
      $display("test_fixed: data=%h enc=%0d", vecs[i], Encoded_Value_Out);
    end
    // Consume without a new accept: valid drops, data holds.
    Valid_In = 1'b0;
    tick();
    checks++;
    if (Valid_Out !== 1'b0 || Encoded_Value_Out !== 3'd7) begin
      errors++;
      $display("FAIL fixed_drain got v=%b enc=%0d exp v=0 enc=7", Valid_Out, Encoded_Value_Out);
    end
    $display("test_fixed: drained valid=%b enc=%0d", Valid_Out, Encoded_Value_Out);
  endtask

  task automatic test_rr_wrap();
    logic [W-1:0] exp_seq [9];
    exp_seq[0] = 3'd7; exp_seq[1] = 3'd6; exp_seq[2] = 3'd5;
    exp_seq[3] = 3'd4; exp_seq[4] = 3'd3; exp_seq[5] = 3'd2;
    exp_seq[6] = 3'd1; exp_seq[7] = 3'd0; exp_seq[8] = 3'd7;
    do_reset();
    Mode_In  = 1'b1;
    Data_In  = 8'hFF;
    Valid_In = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (Valid_Out !== 1'b1 || Encoded_Value_Out !== exp_seq[i]) begin
        errors++;
        $display("FAIL rr_wrap_%0d got v=%b enc=%0d exp v=1 enc=%0d", i, Valid_Out, Encoded_Value_Out, exp_seq[i]);
      end
      $display("test_rr_wrap: step %0d enc=%0d", i, Encoded_Value_Out);
    end
    Valid_In = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    Mode_In  = 1'b0;
    Data_In  = 8'h10;
    Valid_In = 1'b1;
    tick();
    checks++;
    if (Valid_Out !== 1'b1 || Encoded_Value_Out !== 3'd4) begin
      errors++;
      $display("FAIL bp_first got v=%b enc=%0d exp v=1 enc=4", Valid_Out, Encoded_Value_Out);
    end
    Ready_In = 1'b0;
    Data_In  = 8'h80;
    #1;
    checks++;
    if (Ready_Out !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", Ready_Out); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Valid_Out !== 1'b1 || Encoded_Value_Out !== 3'd4 || Ready_Out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b enc=%0d rdy=%b exp v=1 enc=4 rdy=0",
                 i, Valid_Out, Encoded_Value_Out, Ready_Out);
      end
      $display("test_backpressure: hold %0d enc=%0d", i, Encoded_Value_Out);
    end
    Ready_In = 1'b1;
    #1;
    checks++;
    if (Ready_Out !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", Ready_Out); end
    tick();
    Valid_In = 1'b0;
    checks++;
    if (Valid_Out !== 1'b1 || Encoded_Value_Out !== 3'd7) begin
      errors++;
      $display("FAIL bp_second got v=%b enc=%0d exp v=1 enc=7", Valid_Out, Encoded_Value_Out);
    end
    $display("test_backpressure: released enc=%0d", Encoded_Value_Out);
    tick();
  endtask

  task automatic test_no_request();
    do_reset();
    Mode_In  = 1'b1;
    Valid_In = 1'b1;
    Data_In  = 8'hFF;
    tick();
    checks++;
    if (Encoded_Value_Out !== 3'd7) begin errors++; $display("FAIL nr_first got %0d exp 7", Encoded_Value_Out); end
    Data_In = 8'h00;
    tick();
    checks++;
    if (Valid_Out !== 1'b1 || No_Request_Out !== 1'b1 || Encoded_Value_Out !== 3'd0) begin
      errors++;
      $display("FAIL nr_zero got v=%b nr=%b enc=%0d exp v=1 nr=1 enc=0", Valid_Out, No_Request_Out, Encoded_Value_Out);
    end
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
    checks++;
    if (Grant_OneHot_Out !== 8'h00) begin errors++; $display("FAIL nr_onehot got %h exp 00", Grant_OneHot_Out); end
`endif
    Data_In = 8'hFF;
    tick();
    Valid_In = 1'b0;
    checks++;
    if (No_Request_Out !== 1'b0 || Encoded_Value_Out !== 3'd6) begin
      errors++;
      $display("FAIL nr_resume got nr=%b enc=%0d exp nr=0 enc=6", No_Request_Out, Encoded_Value_Out);
    end
    $display("test_no_request: resumed enc=%0d", Encoded_Value_Out);
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    Mode_In  = 1'b1;
    Valid_In = 1'b1;
    Data_In  = 8'hFF;
    tick();
    tick();
    checks++;
    if (Encoded_Value_Out !== 3'd6) begin errors++; $display("FAIL mid_pre got %0d exp 6", Encoded_Value_Out); end
    // Reset wins over the simultaneous accept.
    Reset_In = 1'b1;
    tick();
    Reset_In = 1'b0;
    Valid_In = 1'b0;
    checks++;
    if (Valid_Out !== 1'b0 || Encoded_Value_Out !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b enc=%0d exp v=0 enc=0", Valid_Out, Encoded_Value_Out);
    end
    Valid_In = 1'b1;
    tick();
    Valid_In = 1'b0;
    checks++;
    if (Valid_Out !== 1'b1 || Encoded_Value_Out !== 3'd7) begin
      errors++;
      $display("FAIL mid_after got v=%b enc=%0d exp v=1 enc=7", Valid_Out, Encoded_Value_Out);
    end
    $display("test_reset_midstream: after reset enc=%0d", Encoded_Value_Out);
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    Enable_In = 1'b0;
    Valid_In  = 1'b1;
    Data_In   = 8'h01;
    #1;
    checks++;
    if (Ready_Out !== 1'b0) begin errors++; $display("FAIL en_ready got %b exp 0", Ready_Out); end
    tick();
    checks++;
    if (Valid_Out !== 1'b0) begin errors++; $display("FAIL en_blocked got v=%b exp 0", Valid_Out); end
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
    checks++;
    if (Grant_OneHot_Out !== 8'h00) begin errors++; $display("FAIL en_onehot_off got %h exp 00", Grant_OneHot_Out); end
`endif
    Enable_In = 1'b1;
    tick();
    Valid_In = 1'b0;
    checks++;
    if (Valid_Out !== 1'b1 || Encoded_Value_Out !== 3'd0 || No_Request_Out !== 1'b0) begin
      errors++;
      $display("FAIL en_accept got v=%b enc=%0d nr=%b exp v=1 enc=0 nr=0", Valid_Out, Encoded_Value_Out, No_Request_Out);
    end
`ifdef HIGH_PRIORITY_ENCODER_N_ONEHOT_EN
    checks++;
    if (Grant_OneHot_Out !== 8'h01) begin errors++; $display("FAIL en_onehot_on got %h exp 01", Grant_OneHot_Out); end
`endif
    // Output still drains with Enable_In low.
    Enable_In = 1'b0;
    tick();
    checks++;
    if (Valid_Out !== 1'b0) begin errors++; $display("FAIL en_drain got v=%b exp 0", Valid_Out); end
    $display("test_enable: drained with enable low valid=%b", Valid_Out);
    Enable_In = 1'b1;
  endtask

  initial begin
    Reset_In  = 1'b1;
    Enable_In = 1'b1;
    Mode_In   = 1'b0;
    Data_In   = '0;
    Valid_In  = 1'b0;
    Ready_In  = 1'b1;
    test_reset();
    test_fixed();
    test_rr_wrap();
    test_backpressure();
    test_no_request();
    test_reset_midstream();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
